// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-to-1 stream multiplexer.
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; never below one bit.
  function automatic int selw(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction
endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping, as one-hot grant plus index.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx,
  output logic            vld
);
  // Walk offsets downward so the smallest offset from ptr is the final winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = SELW'(k);
        vld    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 registered stream mux, fixed select or round-robin (round-robin present only with STREAM_MUX_RR_EN).
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SELW     = selw(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Resetn,
  input  logic [CHANNELS*WIDTH-1:0] In_Data,
  input  logic [CHANNELS-1:0]       In_Valid,
  output logic [CHANNELS-1:0]       In_Ready,
  input  logic [SELW-1:0]           Select,
  input  logic                      Mode,
  output logic [WIDTH-1:0]          Out_Data,
  output logic [SELW-1:0]           Out_Chan,
  output logic                      Out_Valid,
  input  logic                      Out_Ready
);
  logic                load;
  logic                fix_vld;
  logic [SELW-1:0]     fix_idx;
  logic [CHANNELS-1:0] fix_oh;
  logic                gnt_vld;
  logic [SELW-1:0]     gnt_idx;
  logic [CHANNELS-1:0] gnt_oh;

  assign load = !Out_Valid || Out_Ready;

  // Out-of-range Select matches no k, so it yields no grant.
  always_comb begin
    fix_vld = 1'b0;
    fix_idx = '0;
    fix_oh  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (Select == SELW'(k) && In_Valid[k]) begin
        fix_vld   = 1'b1;
        fix_idx   = SELW'(k);
        fix_oh[k] = 1'b1;
      end
    end
  end

`ifdef STREAM_MUX_RR_EN
  logic                ptr_q;
  logic [SELW-1:0]     ptr;
  logic                use_rr;
  logic [CHANNELS-1:0] rr_gnt;
  logic [SELW-1:0]     rr_idx;
  logic                rr_vld;

  assign ptr_q  = 1'b0;
  assign use_rr = (Mode == MODE_RR);

  rr_arbiter #(.N(CHANNELS), .SELW(SELW)) u_arb (
    .req (In_Valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .vld (rr_vld)
  );

  assign gnt_vld = use_rr ? rr_vld : fix_vld;
  assign gnt_idx = use_rr ? rr_idx : fix_idx;
  assign gnt_oh  = use_rr ? rr_gnt : fix_oh;

  // Only round-robin transfers advance the pointer.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn)
      ptr <= '0;
    else if (load && gnt_vld && use_rr)
      ptr <= (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + SELW'(1);
  end

  logic unused_ptr_q;
  assign unused_ptr_q = ptr_q;
`else
  logic unused_mode;
  assign unused_mode = Mode;
  assign gnt_vld     = fix_vld;
  assign gnt_idx     = fix_idx;
  assign gnt_oh      = fix_oh;
`endif

  // Gated by Resetn so no input handshake can complete while reset is held.
  assign In_Ready = (Resetn && load && gnt_vld) ? gnt_oh : '0;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Chan  <= '0;
    end else if (load) begin
      Out_Valid <= gnt_vld;
      if (gnt_vld) begin
        Out_Data <= In_Data[int'(gnt_idx)*WIDTH +: WIDTH];
        Out_Chan <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1 against a transaction-level reference model.
module tb_stream_mux_nto1;
  localparam int W = 32;
  localparam int C = 4;

  logic           Clk = 1'b0;
  logic           Resetn;
  logic [C*W-1:0] In_Data;
  logic [C-1:0]   In_Valid;
  logic [C-1:0]   In_Ready;
  logic [1:0]     Select;
  logic           Mode;
  logic [W-1:0]   Out_Data;
  logic [1:0]     Out_Chan;
  logic           Out_Valid;
  logic           Out_Ready;

  // Three-channel instance to reach Select >= CHANNELS.
  logic [3*W-1:0] In_Data3;
  logic [2:0]     In_Valid3;
  logic [2:0]     In_Ready3;
  logic [W-1:0]   Out_Data3;
  logic [1:0]     Out_Chan3;
  logic           Out_Valid3;

  always #5 Clk = ~Clk;

  stream_mux_nto1 #(.WIDTH(W), .CHANNELS(C)) dut (
    .Clk(Clk), .Resetn(Resetn), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Select(Select), .Mode(Mode), .Out_Data(Out_Data),
    .Out_Chan(Out_Chan), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
  );

  stream_mux_nto1 #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .Clk(Clk), .Resetn(Resetn), .In_Data(In_Data3), .In_Valid(In_Valid3),
    .In_Ready(In_Ready3), .Select(2'd3), .Mode(1'b0), .Out_Data(Out_Data3),
    .Out_Chan(Out_Chan3), .Out_Valid(Out_Valid3), .Out_Ready(1'b1)
  );

`ifdef STREAM_MUX_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: the word the downstream side currently sees, and the arbitration pointer.
  bit      m_valid;
  int      m_chan;
  int      m_data;
  int      m_ptr;
  int      words[C];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel that the spec's rules grant this cycle, or -1.
  function automatic int pick();
    int g = -1;
    if (RR_BUILD && Mode) begin
      for (int off = C - 1; off >= 0; off--)
        if (In_Valid[(m_ptr + off) % C]) g = (m_ptr + off) % C;
    end else if (int'(Select) < C && In_Valid[Select]) begin
      g = int'(Select);
    end
    return g;
  endfunction

  task automatic set_words();
    for (int k = 0; k < C; k++) In_Data[k*W +: W] = words[k];
  endtask

  // One clock: check handshake, advance model on the edge, check registered outputs.
  task automatic cycle(input string tag);
    int  g;
    bit  load;
    #1;
    g    = pick();
    load = !m_valid || Out_Ready;
    chk({tag, ".rdy"}, 32'(In_Ready), (load && g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge Clk);
    if (load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_chan = g;
        m_data = words[g];
        if (RR_BUILD && Mode) m_ptr = (g + 1) % C;
      end
    end
    #1;
    chk({tag, ".vld"}, 32'(Out_Valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".dat"}, Out_Data, m_data);
      chk({tag, ".chn"}, 32'(Out_Chan), m_chan);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_chan = 0; m_data = 0; m_ptr = 0;
  endtask

  initial begin
    Resetn = 1'b0; In_Valid = '0; In_Data = '0; Select = '0; Mode = 1'b0; Out_Ready = 1'b0;
    In_Data3 = {32'h33, 32'h22, 32'h11}; In_Valid3 = 3'b111;
    for (int k = 0; k < C; k++) words[k] = 0;
    model_reset();
    #12;
    chk("rst.vld", 32'(Out_Valid), 0);
    chk("rst.dat", Out_Data, 0);
    chk("rst.chn", 32'(Out_Chan), 0);
    chk("rst.rdy", 32'(In_Ready), 0);
    @(negedge Clk); Resetn = 1'b1;
    @(posedge Clk); #1;

    // Fixed select of channel 2.
    words = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0}; set_words();
    Mode = 1'b0; Select = 2'd2; In_Valid = 4'b0100; Out_Ready = 1'b1;
    #1; chk("fix.rdy", 32'(In_Ready), 32'b0100);
    cycle("fix");
    chk("fix.out", Out_Data, 32'hDEADBEEF);
    chk("fix.ch", 32'(Out_Chan), 2);

    // Round-robin over all valid channels.
    words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; set_words();
    Mode = 1'b1; In_Valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle("rr5");
      if (RR_BUILD) chk("rr5.seq", 32'(Out_Chan), i % C);
    end

    // Backpressure holds a word of 0x11.
    Mode = 1'b0; Select = 2'd1; words[1] = 32'h11; set_words(); In_Valid = 4'b0010;
    cycle("bp.ld");
    words[1] = 32'h22; set_words(); Out_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp.hold");
      chk("bp.held", Out_Data, 32'h11);
    end
    Out_Ready = 1'b1;
    cycle("bp.go");
    chk("bp.next", Out_Data, 32'h22);

    // Drive pointer to 3 by a transfer from channel 2, then wrap to channel 0.
    Mode = 1'b1; In_Valid = 4'b0100; cycle("wrap.set");
    In_Valid = 4'b0011; cycle("wrap.g0");
    if (RR_BUILD) chk("wrap.ch0", 32'(Out_Chan), 0);
    cycle("wrap.g1");
    if (RR_BUILD) chk("wrap.ch1", 32'(Out_Chan), 1);

    // Out-of-range select on a 3-channel mux never grants.
    chk("oor.rdy", 32'(In_Ready3), 0);
    chk("oor.vld", 32'(Out_Valid3), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < C; k++) words[k] = $urandom;
      set_words();
      In_Valid  = 4'($urandom);
      Select    = 2'($urandom);
      Mode      = 1'($urandom);
      Out_Ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    // Asynchronous reset mid-stream.
    Mode = 1'b0; Select = 2'd3; words[3] = 32'h5A5A; set_words(); In_Valid = 4'b1000; Out_Ready = 1'b0;
    cycle("ar.ld");
    #2; Resetn = 1'b0; #1;
    model_reset();
    chk("ar.vld", 32'(Out_Valid), 0);
    chk("ar.dat", Out_Data, 0);
    chk("ar.rdy", 32'(In_Ready), 0);
    @(negedge Clk); Resetn = 1'b1;
    Mode = 1'b1; In_Valid = 4'b1111; Out_Ready = 1'b1;
    cycle("ar.first");
    if (RR_BUILD) chk("ar.ch0", 32'(Out_Chan), 0);

    // Mode=1 with Select=1: fixed build must keep granting channel 1.
    Select = 2'd1; In_Valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      cycle("m41");
      if (!RR_BUILD) chk("m41.ch1", 32'(Out_Chan), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
